sdram_write: RTL

//  Single-burst SDRAM write engine; transmit-side counterpart of the SDRAM read engine.

---
 rtl/sdram_write.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_write.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_write
//  Purpose  : Single-burst SDRAM write engine. Buffers BURST_LEN words, then
//             issues ACTIVE -> WRITE (auto-precharge) -> data -> recovery.
//  Option   : SDRAM_WRITE_BYTEMASK_EN adds per-word byte masks (iwmask).
//  Revision : 1.0
// ============================================================================
module sdram_write #(
    parameter int BURST_LEN = 8,
    parameter int T_RCD     = 1,
    parameter int T_WRP     = 4
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        ienb,
    input  logic        ireq,
    input  logic [12:0] irow,
    input  logic [9:0]  icolumn,
    input  logic [1:0]  ibank,
    input  logic [15:0] iwdata,
    input  logic        iwvalid,
`ifdef SDRAM_WRITE_BYTEMASK_EN
    input  logic [1:0]  iwmask,
`endif
    output logic        owready,
    output logic        obusy,
    output logic        ofin,
    output logic        DRAM_CLK,
    output logic        DRAM_CKE,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_UDQM,
    output logic        DRAM_LDQM,
    output logic [15:0] DRAM_DQ
);

    localparam int c_AW   = $clog2(BURST_LEN);
    localparam int c_CW   = c_AW + 1;
    localparam int c_DMAX = (T_RCD > T_WRP) ? T_RCD : T_WRP;
    localparam int c_DW   = $clog2(c_DMAX + 1);

    localparam logic [c_CW-1:0] c_FULL    = c_CW'(BURST_LEN);
    localparam logic [3:0]      c_CMD_NOP = 4'b0111;
    localparam logic [3:0]      c_CMD_ACT = 4'b0011;
    localparam logic [3:0]      c_CMD_WR  = 4'b0100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACT     = 3'd1,
        S_RCD     = 3'd2,
        S_WRITE   = 3'd3,
        S_BURST   = 3'd4,
        S_RECOVER = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   r_rptr;
    logic [c_DW-1:0]   r_dly;
    logic [3:0]        r_cmd;
    logic [12:0]       r_addr;
    logic [1:0]        r_ba;
    logic [1:0]        r_dqm;
    logic [15:0]       r_dq;
    logic              r_dq_oe;
    logic              r_ofin;
    logic [15:0]       r_buf [BURST_LEN];

    logic              w_accept;
    logic [c_AW-1:0]   w_widx;
    logic [c_AW-1:0]   w_ridx;
    logic [15:0]       w_rdata;
    logic [1:0]        w_rmask;

    assign owready  = (r_state == S_IDLE) && (r_count < c_FULL);
    assign w_accept = iwvalid & owready;
    assign w_widx   = r_count[c_AW-1:0];
    assign w_ridx   = r_rptr[c_AW-1:0];
    assign w_rdata  = r_buf[w_ridx];

    // Buffer contents need no reset: the word count decides what is valid.
    always_ff @(posedge iclk) begin
        if (w_accept)
            r_buf[w_widx] <= iwdata;
    end

`ifdef SDRAM_WRITE_BYTEMASK_EN
    logic [1:0] r_mbuf [BURST_LEN];

    always_ff @(posedge iclk) begin
        if (w_accept)
            r_mbuf[w_widx] <= iwmask;
    end

    assign w_rmask = r_mbuf[w_ridx];
`else
    assign w_rmask = 2'b00;
`endif

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_rptr  <= '0;
            r_dly   <= '0;
            r_cmd   <= c_CMD_NOP;
            r_addr  <= '0;
            r_ba    <= '0;
            r_dqm   <= 2'b11;
            r_dq    <= '0;
            r_dq_oe <= 1'b0;
            r_ofin  <= 1'b0;
        end else begin
            r_ofin <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd   <= c_CMD_NOP;
                    r_dqm   <= 2'b11;
                    r_dq_oe <= 1'b0;
                    if (w_accept)
                        r_count <= r_count + c_CW'(1);
                    if (ireq && ienb && (r_count == c_FULL)) begin
                        r_state <= S_ACT;
                        r_cmd   <= c_CMD_ACT;
                        r_addr  <= irow;
                        r_ba    <= ibank;
                    end
                end
                S_ACT: begin
                    r_state <= S_RCD;
                    r_cmd   <= c_CMD_NOP;
                    r_dly   <= c_DW'(T_RCD - 1);
                end
                S_RCD: begin
                    if (r_dly == '0) begin
                        // Read pointer is 0 here, so w_rdata is the first word.
                        r_state <= S_WRITE;
                        r_cmd   <= c_CMD_WR;
                        r_addr  <= {3'b001, icolumn};
                        r_ba    <= ibank;
                        r_dq    <= w_rdata;
                        r_dqm   <= w_rmask;
                        r_dq_oe <= 1'b1;
                        r_rptr  <= r_rptr + c_CW'(1);
                    end else begin
                        r_dly <= r_dly - c_DW'(1);
                    end
                end
                S_WRITE: begin
                    r_state <= S_BURST;
                    r_cmd   <= c_CMD_NOP;
                    r_dq    <= w_rdata;
                    r_dqm   <= w_rmask;
                    r_rptr  <= r_rptr + c_CW'(1);
                end
                S_BURST: begin
                    if (r_rptr == c_FULL) begin
                        r_state <= S_RECOVER;
                        r_dq_oe <= 1'b0;
                        r_dqm   <= 2'b11;
                        r_dly   <= c_DW'(T_WRP - 1);
                    end else begin
                        r_dq   <= w_rdata;
                        r_dqm  <= w_rmask;
                        r_rptr <= r_rptr + c_CW'(1);
                    end
                end
                S_RECOVER: begin
                    if (r_dly == '0) begin
                        r_state <= S_FIN;
                        r_ofin  <= 1'b1;
                    end else begin
                        r_dly <= r_dly - c_DW'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_rptr  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign obusy = (r_state != S_IDLE);
    assign ofin  = r_ofin;

    // Pins are released whenever another engine owns the bus.
    assign DRAM_CLK   = ienb ? ~iclk      : 1'bz;
    assign DRAM_CKE   = ienb ? 1'b1       : 1'bz;
    assign DRAM_CS_N  = ienb ? r_cmd[3]   : 1'bz;
    assign DRAM_RAS_N = ienb ? r_cmd[2]   : 1'bz;
    assign DRAM_CAS_N = ienb ? r_cmd[1]   : 1'bz;
    assign DRAM_WE_N  = ienb ? r_cmd[0]   : 1'bz;
    assign DRAM_ADDR  = ienb ? r_addr     : 13'bz;
    assign DRAM_BA    = ienb ? r_ba       : 2'bz;
    assign DRAM_UDQM  = ienb ? r_dqm[1]   : 1'bz;
    assign DRAM_LDQM  = ienb ? r_dqm[0]   : 1'bz;
    assign DRAM_DQ    = (ienb && r_dq_oe) ? r_dq : 16'bz;

endmodule
`default_nettype wire
